// File: rtl/hilo_mac_unit_pkg.sv
// hilo_mac_unit_pkg: shared widths, op and state encodings for the HI/LO MAC engine.
// Also provides the operand magnitude helper used when latching signed operands.
package hilo_mac_unit_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    // 2'b11 is not named: it falls through to MULT behaviour.
    localparam logic [1:0] MacMult = 2'b00;
    localparam logic [1:0] MacMadd = 2'b01;
    localparam logic [1:0] MacMsub = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MUL_LO = 3'd1,
        MUL_HI = 3'd2,
        ACC    = 3'd3,
        DONE   = 3'd4
    } mac_state_e;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [RegBus-1:0] mag32(
        input logic [RegBus-1:0] v,
        input logic              sgn
    );
        return (sgn && v[RegBus-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_mac_unit_mul32x16.sv
// mul32x16: unsigned 32x16 -> 48-bit combinational partial product.
// Ports: a (32), b (16) in; p (48) out.
module mul32x16 (
    input  logic [31:0] a,
    input  logic [15:0] b,
    output logic [47:0] p
);

    assign p = {16'b0, a} * {32'b0, b};

endmodule

// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit: multi-cycle MULT/MADD/MSUB engine for EX, stalls ctrl while busy.
// Ports: clk, rst (async low), start/annul/hold, op, signed, operands, hilo in; result, ready, stallreq out.
module hilo_mac_unit
    import hilo_mac_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    annul_i,
    input  logic                    hold_i,
    input  logic [1:0]              op_i,
    input  logic                    signed_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic [DoubleRegBus-1:0] hilo_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o,
    output logic                    stallreq_o
);

    mac_state_e state_q, state_d;

    logic [RegBus-1:0]       a_q, b_q;
    logic                    neg_q;
    logic [1:0]              op_q;
    logic [DoubleRegBus-1:0] hilo_q, acc_q, result_q;
    logic                    ready_q;

    logic                    start_ok;
    logic [15:0]             b_half;
    logic [47:0]             pp;
    logic [DoubleRegBus-1:0] prod, sum;

    assign start_ok = start_i & ~annul_i;

    // One multiplier serves both halves; the state picks the multiplier slice.
    assign b_half = (state_q == MUL_HI) ? b_q[31:16] : b_q[15:0];

    mul32x16 u_mul (
        .a (a_q),
        .b (b_half),
        .p (pp)
    );

    assign prod = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        sum = prod;
        case (op_q)
            MacMadd: sum = hilo_q + prod;
            MacMsub: sum = hilo_q - prod;
            default: sum = prod;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && annul_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_ok) state_d = MUL_LO;
                MUL_LO:  state_d = MUL_HI;
                MUL_HI:  state_d = ACC;
                ACC:     state_d = DONE;
                DONE:    if (!hold_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            op_q     <= MacMult;
            hilo_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (state_q != IDLE && annul_i) begin
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        a_q    <= mag32(opdata1_i, signed_i);
                        b_q    <= mag32(opdata2_i, signed_i);
                        neg_q  <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        op_q   <= op_i;
                        hilo_q <= hilo_i;
                    end
                end
                MUL_LO: acc_q <= {16'b0, pp};
                MUL_HI: acc_q <= acc_q + ({16'b0, pp} << 16);
                ACC: begin
                    result_q <= sum;
                    ready_q  <= 1'b1;
                end
                DONE:    if (!hold_i) ready_q <= 1'b0;
                default: ready_q <= 1'b0;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

    // Gated by rst so the request drops immediately during reset.
    assign stallreq_o = rst & ((state_q == IDLE && start_ok) ||
                               state_q == MUL_LO ||
                               state_q == MUL_HI ||
                               state_q == ACC);

endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb_hilo_mac_unit: directed self-checking bench for hilo_mac_unit.
// Drives inputs 1 time unit after the rising edge and samples there too.
module tb_hilo_mac_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        hold_i;
    logic [1:0]  op_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] hilo_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int tests = 0;
    int fails = 0;

    hilo_mac_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .hold_i     (hold_i),
        .op_i       (op_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .hilo_i     (hilo_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus only: issues one op, scrambles inputs after the start edge,
    // waits (bounded) for ready, then releases start for one more edge.
    task automatic run_op(
        input  logic [1:0]  op,
        input  logic        sgn,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [63:0] hilo,
        output int          cyc,
        output int          stalls,
        output logic [63:0] res,
        output logic        rdy_after
    );
        op_i      = op;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        hilo_i    = hilo;
        start_i   = 1'b1;
        cyc       = 0;
        stalls    = 0;
        #1;
        while (!ready_o && cyc < 12) begin
            if (stallreq_o) stalls++;
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'h1234_5678;
                hilo_i    = 64'hCAFE_F00D_0BAD_BEEF;
                op_i      = 2'b01;
                signed_i  = ~sgn;
            end
        end
        res     = result_o;
        start_i = 1'b0;
        @(posedge clk); #1;
        rdy_after = ready_o;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        start_i   = 1'b1;
        annul_i   = 1'b0;
        hold_i    = 1'b0;
        op_i      = 2'b00;
        signed_i  = 1'b0;
        opdata1_i = 32'd3;
        opdata2_i = 32'd4;
        hilo_i    = 64'd0;
        #2;
        tests++;
        if (result_o !== 64'd0) begin
            fails++;
            $display("FAIL reset_result: got %h want 0", result_o);
        end
        tests++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0", ready_o);
        end
        tests++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_stallreq: got %b want 0", stallreq_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(
        input string       name,
        input int          cyc,
        input int          stalls,
        input logic [63:0] res,
        input logic        rdy_after,
        input logic [63:0] exp
    );
        tests++;
        if (cyc != 4) begin
            fails++;
            $display("FAIL %s_latency: got %0d want 4", name, cyc);
        end
        tests++;
        if (stalls != 4) begin
            fails++;
            $display("FAIL %s_stall_cycles: got %0d want 4", name, stalls);
        end
        tests++;
        if (res !== exp) begin
            fails++;
            $display("FAIL %s_result: got %h want %h", name, res, exp);
        end
        tests++;
        if (rdy_after !== 1'b0) begin
            fails++;
            $display("FAIL %s_ready_clear: got %b want 0", name, rdy_after);
        end
    endtask

    task automatic test_mult();
        logic [1:0]  ops [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
        logic        sg  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] va  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'd3};
        logic [31:0] vb  [4] = '{32'hFFFF_FFFF, 32'd7,
                                 32'h8000_0000, 32'd4};
        logic [63:0] vh  [4] = '{64'd0, 64'd0, 64'd5, 64'h1234};
        logic [63:0] ve  [4] = '{64'hFFFF_FFFE_0000_0001,
                                 64'hFFFF_FFFF_FFFF_FFEB,
                                 64'h4000_0000_0000_0000,
                                 64'd12};
        int cyc, stalls;
        logic [63:0] res;
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], sg[i], va[i], vb[i], vh[i], cyc, stalls, res, rdy);
            check_op($sformatf("mult%0d", i), cyc, stalls, res, rdy, ve[i]);
        end
    endtask

    task automatic test_madd_msub();
        int cyc, stalls;
        logic [63:0] res;
        logic rdy;
        run_op(2'b01, 1'b1, 32'd5, 32'hFFFF_FFFE, 64'h10,
               cyc, stalls, res, rdy);
        check_op("madd_signed", cyc, stalls, res, rdy, 64'd6);
        run_op(2'b10, 1'b0, 32'd1, 32'd1, 64'd0,
               cyc, stalls, res, rdy);
        check_op("msub_wrap", cyc, stalls, res, rdy, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b10, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 64'd100,
               cyc, stalls, res, rdy);
        check_op("msub_signed", cyc, stalls, res, rdy, 64'h50);
    endtask

    task automatic test_annul();
        logic seen;
        int cyc, stalls;
        logic [63:0] res;
        logic rdy;
        op_i      = 2'b00;
        signed_i  = 1'b0;
        opdata1_i = 32'd7;
        opdata2_i = 32'd9;
        hilo_i    = 64'd0;
        start_i   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        annul_i = 1'b1;
        #1;
        tests++;
        if (stallreq_o !== 1'b1) begin
            fails++;
            $display("FAIL annul_busy_stall: got %b want 1", stallreq_o);
        end
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        #1;
        tests++;
        if (stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL annul_stallreq: got %b want 0", stallreq_o);
        end
        tests++;
        if (result_o !== 64'd0) begin
            fails++;
            $display("FAIL annul_result: got %h want 0", result_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ready_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL annul_ready: got %b want 0", seen);
        end
        run_op(2'b00, 1'b0, 32'd2, 32'd3, 64'd0, cyc, stalls, res, rdy);
        check_op("after_annul", cyc, stalls, res, rdy, 64'd6);
    endtask

    task automatic test_hold();
        int cyc;
        op_i      = 2'b00;
        signed_i  = 1'b0;
        opdata1_i = 32'd4;
        opdata2_i = 32'd5;
        hilo_i    = 64'd0;
        start_i   = 1'b1;
        cyc       = 0;
        #1;
        while (!ready_o && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        tests++;
        if (cyc != 4) begin
            fails++;
            $display("FAIL hold_latency: got %0d want 4", cyc);
        end
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (ready_o !== 1'b1 || stallreq_o !== 1'b0 ||
                result_o !== 64'd20) begin
                fails++;
                $display("FAIL hold_done%0d: got rdy=%b stall=%b res=%h want 1 0 %h",
                         i, ready_o, stallreq_o, result_o, 64'd20);
            end
        end
        hold_i  = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (ready_o !== 1'b0 || stallreq_o !== 1'b0 ||
            result_o !== 64'd20) begin
            fails++;
            $display("FAIL hold_release: got rdy=%b stall=%b res=%h want 0 0 %h",
                     ready_o, stallreq_o, result_o, 64'd20);
        end
    endtask

    task automatic test_async_reset();
        int cyc, stalls;
        logic [63:0] res;
        logic rdy;
        op_i      = 2'b00;
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF_FFFF;
        opdata2_i = 32'd2;
        hilo_i    = 64'd0;
        start_i   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (stallreq_o !== 1'b1 || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL acc_state: got stall=%b rdy=%b want 1 0",
                     stallreq_o, ready_o);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 ||
            stallreq_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b res=%h stall=%b want 0 0 0",
                     ready_o, result_o, stallreq_o);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        run_op(2'b00, 1'b0, 32'h0001_0000, 32'h0001_0000, 64'd0,
               cyc, stalls, res, rdy);
        check_op("post_reset", cyc, stalls, res, rdy, 64'h1_0000_0000);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_madd_msub();
        test_annul();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_mac_unit.md
Name: hilo_mac_unit

Overview:
- Multi-cycle multiply / multiply-accumulate engine in the EX stage. Executes MULT, MADD and MSUB.
- Consumes the HI/LO value that the EX/MEM register set feeds back, and holds its own intermediate state instead of passing it through EX/MEM.
- Raises a stall request to ctrl while it works, then presents a registered 64-bit {hi,lo} result that EX forwards to mem_hi/mem_lo.

Parameters:
- none (widths come from RegBus = 32 and DoubleRegBus = 64 in defines.v)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset; state clears immediately while rst == 0
- start_i  in  1  EX holds a MULT/MADD/MSUB instruction
- annul_i  in  1  flush; discard the operation in flight
- hold_i  in  1  EX is frozen by a later stage (stall[2] from ctrl)
- op_i  in  2  00 MULT, 01 MADD, 10 MSUB, 11 is treated as MULT
- signed_i  in  1  1 = signed operands
- opdata1_i  in  32  multiplicand
- opdata2_i  in  32  multiplier
- hilo_i  in  64  current {HI,LO} after forwarding
- result_o  out  64  {hi,lo} result
- ready_o  out  1  result_o is valid
- stallreq_o  out  1  stall request to ctrl

Behaviour:
- Reset (rst == 0, async): state = IDLE; result_o, ready_o, all internal operand/accumulator registers = 0. stallreq_o = 0.
- States: IDLE, MUL_LO, MUL_HI, ACC, DONE.
- IDLE, with start_i = 1 and annul_i = 0:
  - Latch |opdata1| and |opdata2| (magnitudes only when signed_i = 1; otherwise raw values).
  - Latch the product sign: neg = signed_i & (op1[31] ^ op2[31]).
  - Latch op_i and hilo_i.
  - Next state is MUL_LO. Otherwise stay in IDLE.
- MUL_LO: acc <= a * b[15:0], 48-bit unsigned. Next state MUL_HI.
- MUL_HI: acc <= acc + ((a * b[31:16]) << 16), giving a 64-bit unsigned product. Next state ACC.
- ACC:
  - p = neg ? -acc : acc.
  - result_o <= p for MULT, hilo + p for MADD, hilo - p for MSUB. All arithmetic is modulo 2^64.
  - Next state DONE.
- DONE: ready_o = 1 and result_o is stable. Go to IDLE when hold_i = 0; stay in DONE while hold_i = 1. The held instruction is never restarted, even though start_i stays high.
- ready_o is registered: it is 1 only in DONE. Leaving DONE clears ready_o; result_o keeps its last value.
- stallreq_o is combinational: 1 when (IDLE & start_i & ~annul_i) or the state is MUL_LO, MUL_HI or ACC. It is 0 in DONE.
- Latency:
  - start sampled at edge 0; ready_o = 1 in the cycle after edge 3.
  - stallreq_o is high for exactly 4 cycles (cycles 0-3).
- annul_i = 1 in any state except IDLE: next state IDLE, ready_o <= 0, result_o <= 0. annul_i has priority over hold_i and over start_i.
- Operands and hilo_i are sampled only on the IDLE→MUL_LO edge. Changes to them afterwards are ignored.
- Operands do not wrap the multiply: 0x80000000 signed gives a magnitude of 0x80000000 (33rd bit not needed, since the latch is unsigned 32-bit).
- The 11 encoding of op_i behaves exactly as MULT.

Decomposition:
- defines.v gets:
  - op encodings: MacMult, MacMadd, MacMsub
  - state encodings for the five states
  - RegBus / DoubleRegBus (reused)
- One combinational sub-module, mul32x16: unsigned 32×16 → 48-bit partial product. It is instantiated once and shared by MUL_LO and MUL_HI through a mux on b[15:0] / b[31:16].

Test Plan:
- MULT unsigned 0xFFFFFFFF × 0xFFFFFFFF → result_o = 0xFFFFFFFE_00000001. stallreq_o high for 4 cycles; ready_o high on cycle 4.
- MULT signed -3 × 7 → 0xFFFFFFFF_FFFFFFEB. Also signed 0x80000000 × 0x80000000 → 0x40000000_00000000.
- MADD signed, hilo_i = 0x00000000_00000010, 5 × (-2) → 0x00000000_00000006.
- MSUB unsigned, hilo_i = 0, 1 × 1 → 0xFFFFFFFF_FFFFFFFF (wrap-around).
- annul_i pulsed while in MUL_HI:
  - Next cycle: state IDLE, stallreq_o = 0, ready_o never rises, result_o = 0.
  - A following MULT 2 × 3 then completes with 6.
- hold_i = 1 for 3 cycles in DONE with start_i still high: stays in DONE, result_o stable, no restart; returns to IDLE the cycle after hold_i falls.
- rst driven low mid-ACC: ready_o, result_o and stallreq_o go to 0 without a clock edge.
